hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS core: generates the enable and clear strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. Detects Tuse/Tnew data hazards, tracks multi-cycle mult/div occupancy, and sequences the exception and ERET flushes. Sits beside the datapath and consumes pre-decoded register fields from each stage; the pipeline registers themselves remain dumb and obey its strobes.

---
 rtl/cpu_defs.sv | 22 ++
 rtl/md_busy_cnt.sv | 46 ++++
 rtl/hazard_ctrl.sv | 150 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the pipeline sequencing controller: handler entry
// address, pre-decoded field widths, FSM encoding and default mult/div
// latencies.
package cpu_defs;

    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;

    localparam int unsigned REG_W    = 5;
    localparam int unsigned TUSE_W   = 2;
    localparam int unsigned TNEW_W   = 2;
    localparam int unsigned MD_CNT_W = 4;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // RUN: normal sequencing; EXC: one cycle squashing the wrong-path fetch
    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_EXC = 1'b1
    } hz_state_t;

endpackage

// File: rtl/md_busy_cnt.sv
// Loadable down-counter tracking mult/div unit occupancy. A start seen while
// idle loads the operation latency; a start while busy is ignored. busy is
// high exactly the loaded number of cycles, beginning the cycle after start.
module md_busy_cnt
    import cpu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [MD_CNT_W-1:0] MULT_LD = MULT_CYCLES[MD_CNT_W-1:0];
    localparam logic [MD_CNT_W-1:0] DIV_LD  = DIV_CYCLES[MD_CNT_W-1:0];

    logic [MD_CNT_W-1:0] cnt_r;
    logic [MD_CNT_W-1:0] cnt_nxt_s;

    // Next count: load on an accepted start, otherwise count down to zero
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (start && (cnt_r == {MD_CNT_W{1'b0}})) begin
            cnt_nxt_s = is_div ? DIV_LD : MULT_LD;
        end else if (cnt_r != {MD_CNT_W{1'b0}}) begin
            cnt_nxt_s = cnt_r - {{(MD_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {MD_CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    assign busy = (cnt_r != {MD_CNT_W{1'b0}});

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage MIPS core. Produces the
// PC / pipeline-register enable and clear strobes from Tuse/Tnew data
// hazards, mult/div occupancy and exception/ERET flush sequencing.
// Optional feature macro: HAZARD_MD_EN compiles in the mult/div busy counter
// and its D-stage stall term; without it md_busy is 0 and md inputs are
// ignored.
module hazard_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  rs_D,
    input  logic [REG_W-1:0]  rt_D,
    input  logic [TUSE_W-1:0] tuse_rs,
    input  logic [TUSE_W-1:0] tuse_rt,
    input  logic [REG_W-1:0]  wa_E,
    input  logic [REG_W-1:0]  wa_M,
    input  logic [TNEW_W-1:0] tnew_E,
    input  logic [TNEW_W-1:0] tnew_M,
    input  logic              md_use_D,
    input  logic              md_start_E,
    input  logic              md_is_div_E,
    input  logic              exc_req_M,
    input  logic              eret_D,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_clr,
    output logic              id_ex_clr,
    output logic              ex_mem_clr,
    output logic              mem_wb_clr,
    output logic              pc_sel_exc,
    output logic              md_busy
);

    hz_state_t state_r;
    hz_state_t state_nxt_s;

    logic data_haz_s;
    logic md_haz_s;
    logic md_busy_s;
    logic stall_s;

    // A producer blocks D when its result arrives later than D needs it;
    // $zero never creates a dependency.
    assign data_haz_s =
        ((rs_D != 5'd0) && (rs_D == wa_E) && (tuse_rs < tnew_E)) ||
        ((rs_D != 5'd0) && (rs_D == wa_M) && (tuse_rs < tnew_M)) ||
        ((rt_D != 5'd0) && (rt_D == wa_E) && (tuse_rt < tnew_E)) ||
        ((rt_D != 5'd0) && (rt_D == wa_M) && (tuse_rt < tnew_M));

`ifdef HAZARD_MD_EN
    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_cnt (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_E),
        .is_div (md_is_div_E),
        .busy   (md_busy_s)
    );

    // An op starting in E this cycle already occupies the unit for D
    assign md_haz_s = md_use_D && (md_busy_s || md_start_E);
`else
    logic unused_md_s;

    assign md_busy_s   = 1'b0;
    assign md_haz_s    = 1'b0;
    assign unused_md_s = &{1'b0, md_use_D, md_start_E, md_is_div_E,
                           (MULT_CYCLES != 32'd0), (DIV_CYCLES != 32'd0)};
`endif

    assign stall_s = data_haz_s || md_haz_s;

    // Next state: enter EXC on an exception taken in RUN, always leave after one cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (exc_req_M) begin
                    state_nxt_s = ST_EXC;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_EXC: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Strobe decode; priority is exception, then stall, then ERET
    always_comb begin
        pc_en      = 1'b1;
        if_id_en   = 1'b1;
        if_id_clr  = 1'b0;
        id_ex_clr  = 1'b0;
        ex_mem_clr = 1'b0;
        mem_wb_clr = 1'b0;
        pc_sel_exc = 1'b0;
        if (reset) begin
            pc_en = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (exc_req_M) begin
                        if_id_clr  = 1'b1;
                        id_ex_clr  = 1'b1;
                        ex_mem_clr = 1'b1;
                        mem_wb_clr = 1'b1;
                        pc_sel_exc = 1'b1;
                    end else if (stall_s) begin
                        pc_en     = 1'b0;
                        if_id_en  = 1'b0;
                        id_ex_clr = 1'b1;
                    end else if (eret_D) begin
                        if_id_clr = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
                ST_EXC: begin
                    if_id_clr = 1'b1;
                end
                default: begin
                    pc_en = 1'b1;
                end
            endcase
        end
    end

    assign md_busy = md_busy_s && !reset;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with constant
// expectations, then randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_D, rt_D, wa_E, wa_M;
    logic [1:0] tuse_rs, tuse_rt, tnew_E, tnew_M;
    logic       md_use_D, md_start_E, md_is_div_E, exc_req_M, eret_D;
    logic       pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr;
    logic       pc_sel_exc, md_busy;

    int checks   = 0;
    int failures = 0;

    // model state
    int m_left = 0;
    bit m_exc  = 1'b0;

`ifdef HAZARD_MD_EN
    localparam bit MD_ON = 1'b1;
`else
    localparam bit MD_ON = 1'b0;
`endif

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
        .wa_E(wa_E), .wa_M(wa_M), .tnew_E(tnew_E), .tnew_M(tnew_M),
        .md_use_D(md_use_D), .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
        .exc_req_M(exc_req_M), .eret_D(eret_D),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_clr(if_id_clr),
        .id_ex_clr(id_ex_clr), .ex_mem_clr(ex_mem_clr), .mem_wb_clr(mem_wb_clr),
        .pc_sel_exc(pc_sel_exc), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, pc_sel_exc, md_busy}
    function automatic logic [7:0] dut_vec();
        return {pc_en, if_id_en, if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr, pc_sel_exc, md_busy};
    endfunction

    function automatic bit dep(input logic [4:0] src, input logic [1:0] tuse,
                               input logic [4:0] dst, input logic [1:0] tnew);
        return (src != 5'd0) && (src == dst) && (int'(tuse) < int'(tnew));
    endfunction

    function automatic logic [7:0] model_vec();
        bit busy, stall;
        busy  = MD_ON && (m_left > 0);
        stall = dep(rs_D, tuse_rs, wa_E, tnew_E) || dep(rs_D, tuse_rs, wa_M, tnew_M) ||
                dep(rt_D, tuse_rt, wa_E, tnew_E) || dep(rt_D, tuse_rt, wa_M, tnew_M) ||
                (MD_ON && md_use_D && (busy || md_start_E));
        if (reset)     return 8'hC0;
        if (m_exc)     return {7'b1110000, busy};
        if (exc_req_M) return {7'b1111111, busy};
        if (stall)     return {7'b0001000, busy};
        if (eret_D)    return {7'b1110000, busy};
        return {7'b1100000, busy};
    endfunction

    // advance the model across one rising edge using the applied inputs
    task automatic model_step();
        if (reset) begin
            m_left = 0;
            m_exc  = 1'b0;
        end else begin
            m_exc = !m_exc && exc_req_M;
            if (MD_ON) begin
                if (md_start_E && m_left == 0) m_left = md_is_div_E ? 10 : 5;
                else if (m_left > 0)           m_left = m_left - 1;
            end
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0; rs_D = 5'd0; rt_D = 5'd0; wa_E = 5'd0; wa_M = 5'd0;
        tuse_rs = 2'd3; tuse_rt = 2'd3; tnew_E = 2'd0; tnew_M = 2'd0;
        md_use_D = 1'b0; md_start_E = 1'b0; md_is_div_E = 1'b0;
        exc_req_M = 1'b0; eret_D = 1'b0;
    endtask

    // one cycle: compare at negedge (model always, constant when given), then step
    task automatic cyc(input string tag, input bit has_want, input logic [7:0] want);
        @(negedge clk);
        check_eq({tag, "_model"}, {24'd0, dut_vec()}, {24'd0, model_vec()});
        if (has_want) check_eq(tag, {24'd0, dut_vec()}, {24'd0, want});
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); model_step(); #1;
        cyc("reset_idle", 1'b1, 8'hC0);
        reset = 1'b0;
        cyc("post_reset_idle", 1'b1, 8'hC0);

        // RAW on rs against E
        rs_D = 5'd8; tuse_rs = 2'd0; wa_E = 5'd8; tnew_E = 2'd1;
        cyc("rs_stall", 1'b1, 8'h10);
        rs_D = 5'd0;
        cyc("r0_no_stall", 1'b1, 8'hC0);
        rs_D = 5'd8; tnew_E = 2'd0;
        cyc("tnew0_no_stall", 1'b1, 8'hC0);

        // exception overriding a concurrent stall
        clear_inputs();
        rt_D = 5'd3; tuse_rt = 2'd0; wa_M = 5'd3; tnew_M = 2'd2; exc_req_M = 1'b1;
        cyc("exc_flush", 1'b1, 8'hFE);
        clear_inputs();
        cyc("exc_squash", 1'b1, 8'hE0);
        cyc("exc_after_idle", 1'b1, 8'hC0);

        // ERET alone, then ERET behind a stall
        eret_D = 1'b1;
        cyc("eret_clr", 1'b1, 8'hE0);
        rs_D = 5'd5; tuse_rs = 2'd1; wa_M = 5'd5; tnew_M = 2'd2;
        cyc("eret_stalled", 1'b1, 8'h10);
        wa_M = 5'd0;
        cyc("eret_after_stall", 1'b1, 8'hE0);
        clear_inputs();

        if (MD_ON) begin
            // div with D waiting on HI/LO: stalled start cycle + 10 busy cycles
            md_use_D = 1'b1; md_start_E = 1'b1; md_is_div_E = 1'b1;
            cyc("div_start_stall", 1'b1, 8'h10);
            md_start_E = 1'b0; md_is_div_E = 1'b0;
            for (int i = 0; i < 10; i++) cyc("div_busy_stall", 1'b1, 8'h11);
            cyc("div_done", 1'b1, 8'hC0);
            md_use_D = 1'b0;
            // mult without a consumer: 5 busy cycles
            md_start_E = 1'b1;
            cyc("mult_start", 1'b1, 8'hC0);
            md_start_E = 1'b0;
            for (int i = 0; i < 5; i++) cyc("mult_busy", 1'b1, 8'hC1);
            cyc("mult_done", 1'b1, 8'hC0);
            // reset with count at 6
            md_start_E = 1'b1; md_is_div_E = 1'b1;
            cyc("div2_start", 1'b1, 8'hC0);
            md_start_E = 1'b0; md_is_div_E = 1'b0;
            for (int i = 0; i < 4; i++) cyc("div2_busy", 1'b1, 8'hC1);
            reset = 1'b1;
            cyc("reset_mid_count", 1'b1, 8'hC0);
            reset = 1'b0;
            cyc("after_reset_mid_count", 1'b1, 8'hC0);
        end else begin
            md_use_D = 1'b1; md_start_E = 1'b1; md_is_div_E = 1'b1;
            cyc("md_disabled_start", 1'b1, 8'hC0);
            md_start_E = 1'b0;
            cyc("md_disabled_use", 1'b1, 8'hC0);
            clear_inputs();
        end

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            rs_D        = 5'($urandom_range(0, 3));
            rt_D        = 5'($urandom_range(0, 3));
            wa_E        = 5'($urandom_range(0, 3));
            wa_M        = 5'($urandom_range(0, 3));
            tuse_rs     = 2'($urandom_range(0, 3));
            tuse_rt     = 2'($urandom_range(0, 3));
            tnew_E      = 2'($urandom_range(0, 3));
            tnew_M      = 2'($urandom_range(0, 3));
            md_use_D    = ($urandom_range(0, 3) == 0);
            md_start_E  = ($urandom_range(0, 7) == 0);
            md_is_div_E = $urandom_range(0, 1) != 0;
            exc_req_M   = ($urandom_range(0, 15) == 0);
            eret_D      = ($urandom_range(0, 7) == 0);
            cyc("random", 1'b0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
